// File: rtl/instr_collate_stream_pkg.sv
// Shared constants, FIFO entry layout helpers and the per-word action
// encoding for the instruction collate stage.
package instr_collate_stream_pkg;

   localparam int COLLATE_NUM_WF     = 40;
   localparam int COLLATE_WFID_W     = 6;
   localparam int COLLATE_INSTR_W    = 32;
   localparam int COLLATE_PC_W       = 32;
   localparam int COLLATE_FIFO_DEPTH = 4;

   // What an accepted fetch word does to its wavefront slot
   typedef enum logic [2:0] {
      ACT_NONE,    // dropped: bad wfid, flushed, or no word
      ACT_STORE,   // first half of a long instruction parked
      ACT_ORPHAN,  // first half replaced an unfinished first half
      ACT_PAIR,    // second half completes a long instruction
      ACT_SHORT    // single-word instruction
   } act_e;

   // FIFO entry is packed {wfid, long, pc, instr}; instr sits at bit 0
   function automatic int off_pc(input int instr_w);
      return 2 * instr_w;
   endfunction

   function automatic int off_long(input int instr_w, input int pc_w);
      return 2 * instr_w + pc_w;
   endfunction

   function automatic int off_wfid(input int instr_w, input int pc_w);
      return 2 * instr_w + pc_w + 1;
   endfunction

   function automatic int entry_w(input int wfid_w, input int instr_w, input int pc_w);
      return wfid_w + 1 + pc_w + 2 * instr_w;
   endfunction

endpackage

// File: rtl/instr_collate_stream_fifo.sv
// Synchronous FIFO with wrap-bit pointers and an occupancy count.
// The head is read straight out of the storage flops, so out data never
// depends combinationally on the push side. not_full is a flop computed
// from the next count, so a pop on a full FIFO reopens the input a cycle later.
module instr_collate_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [WIDTH-1:0]         head_data,
   output logic                     not_full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      count_q;
   logic [AW:0]      count_next;
   logic             ready_q;
   logic             do_push;
   logic             do_pop;

   // Qualify push/pop against current occupancy and compute the next count
   always_comb begin
      do_push    = push & ready_q;
      do_pop     = pop & (count_q != '0);
      count_next = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Storage array; contents are only ever read below the count, so no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Pointers, count and registered space-available flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_next;
         ready_q <= (count_next < (AW+1)'(DEPTH));
      end
   end

   assign head_valid = (count_q != '0);
   assign head_data  = head_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign not_full   = ready_q;
   assign count      = count_q;

endmodule

// File: rtl/instr_collate_stream.sv
// Collates 32-bit fetch words into whole instructions per wavefront.
// A long instruction's first half is parked in a per-wavefront hold slot
// until its second half arrives; completed instructions queue in a small
// FIFO toward decode. Flush discards a parked half; a parked half that is
// overwritten by another first half raises a one-cycle err_orphan.
module instr_collate_stream
   import instr_collate_stream_pkg::*;
#(
   parameter int NUM_WF     = COLLATE_NUM_WF,
   parameter int WFID_W     = COLLATE_WFID_W,
   parameter int INSTR_W    = COLLATE_INSTR_W,
   parameter int PC_W       = COLLATE_PC_W,
   parameter int FIFO_DEPTH = COLLATE_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WFID_W-1:0]             in_wfid,
   input  logic [INSTR_W-1:0]            in_instr,
   input  logic [PC_W-1:0]               in_pc,
   input  logic                          in_long,
   input  logic                          flush_valid,
   input  logic [WFID_W-1:0]             flush_wfid,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WFID_W-1:0]             out_wfid,
   output logic [2*INSTR_W-1:0]          out_instr,
   output logic [PC_W-1:0]               out_pc,
   output logic                          out_long,
   output logic                          err_orphan,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int EW     = entry_w(WFID_W, INSTR_W, PC_W);
   localparam int O_PC   = off_pc(INSTR_W);
   localparam int O_LONG = off_long(INSTR_W, PC_W);
   localparam int O_WFID = off_wfid(INSTR_W, PC_W);

   logic [NUM_WF-1:0]  pend_q;
   logic [NUM_WF-1:0]  pend_next;
   logic [INSTR_W-1:0] hold_instr [NUM_WF];
   logic [PC_W-1:0]    hold_pc    [NUM_WF];
   logic               err_orphan_q;

   logic               accept;
   logic               wf_ok;
   logic               flush_ok;
   logic               flush_hit;
   act_e               act;
   logic               push;
   logic [EW-1:0]      push_data;
   logic [EW-1:0]      head_data;

   // Classify the incoming word and derive the next pending vector and push entry
   always_comb begin
      accept    = in_valid & in_ready;
      wf_ok     = ({1'b0, in_wfid} < (WFID_W+1)'(NUM_WF));
      flush_ok  = ({1'b0, flush_wfid} < (WFID_W+1)'(NUM_WF));
      flush_hit = flush_valid & (flush_wfid == in_wfid);
      act       = ACT_NONE;
      pend_next = pend_q;
      push      = 1'b0;
      push_data = '0;

      // A flush aimed at the same wavefront kills the word outright
      if (accept && wf_ok && !flush_hit) begin
         if (in_long) act = pend_q[in_wfid] ? ACT_ORPHAN : ACT_STORE;
         else         act = pend_q[in_wfid] ? ACT_PAIR   : ACT_SHORT;
      end

      if (flush_valid && flush_ok) pend_next[flush_wfid] = 1'b0;

      case (act)
         ACT_STORE: pend_next[in_wfid] = 1'b1;
         ACT_PAIR: begin
            pend_next[in_wfid] = 1'b0;
            push      = 1'b1;
            push_data = {in_wfid, 1'b1, hold_pc[in_wfid], in_instr, hold_instr[in_wfid]};
         end
         ACT_SHORT: begin
            push      = 1'b1;
            push_data = {in_wfid, 1'b0, in_pc, {INSTR_W{1'b0}}, in_instr};
         end
         default: ;
      endcase
   end

   // Park first halves; these slots are only read while their pend bit is set
   always_ff @(posedge clk) begin
      if (act == ACT_STORE || act == ACT_ORPHAN) begin
         hold_instr[in_wfid] <= in_instr;
         hold_pc[in_wfid]    <= in_pc;
      end
   end

   // Pending-half flags and the orphan pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_q       <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         pend_q       <= pend_next;
         err_orphan_q <= (act == ACT_ORPHAN);
      end
   end

   instr_collate_stream_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  (push_data),
      .pop        (out_ready),
      .head_valid (out_valid),
      .head_data  (head_data),
      .not_full   (in_ready),
      .count      (fifo_count)
   );

   assign out_instr  = head_data[2*INSTR_W-1:0];
   assign out_pc     = head_data[O_PC +: PC_W];
   assign out_long   = head_data[O_LONG];
   assign out_wfid   = head_data[O_WFID +: WFID_W];
   assign err_orphan = err_orphan_q;

endmodule
